// File: rtl/nic_defs_pkg.sv
// Shared NIC definitions: network payload/interface types, flow-id field location and RX dispatch statistics.
package nic_defs;

    typedef logic [511:0] NetworkPayload;

    typedef struct packed {
        logic          valid;
        NetworkPayload payload;
    } NetworkIf;

    localparam int FLOW_ID_LSB = 0;
    localparam int FLOW_ID_W   = 16;

    typedef struct packed {
        logic [31:0] accepted;
        logic [31:0] drop_full;
        logic [31:0] drop_filter;
    } NetRxStats;

    // Saturating increment: counters hold at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic en);
        return (en && (value != 32'hFFFF_FFFF)) ? value + 32'd1 : value;
    endfunction

endpackage

// File: rtl/net_rx_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; head_q shadows the entry at the read pointer so
// data pushed into an empty FIFO is visible on the very next cycle.
module net_rx_sync_fifo #(
    parameter int DATA_WIDTH = 512,
    parameter int LOG_DEPTH  = 5
) (
    input  logic                  clk,
    input  logic                  srst_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] head_data_o,
    output logic [LOG_DEPTH:0]    level_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int DEPTH = 1 << LOG_DEPTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] head_q;
    logic [LOG_DEPTH:0]    wr_ptr_q, wr_ptr_d;
    logic [LOG_DEPTH:0]    rd_ptr_q, rd_ptr_d;
    logic                  push_en, pop_en;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[LOG_DEPTH] != rd_ptr_q[LOG_DEPTH]) &&
                     (wr_ptr_q[LOG_DEPTH-1:0] == rd_ptr_q[LOG_DEPTH-1:0]);
    assign pop_en  = pop_i & ~empty_o;
    // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
    assign push_en = push_i & (~full_o | pop_en);

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{LOG_DEPTH{1'b0}}, push_en};
        rd_ptr_d = rd_ptr_q + {{LOG_DEPTH{1'b0}}, pop_en};
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr_q[LOG_DEPTH-1:0]] <= push_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (srst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            // The next head is the word being written now when the read pointer catches the write pointer.
            if (rd_ptr_d == wr_ptr_q) begin
                head_q <= push_data_i;
            end else begin
                head_q <= mem[rd_ptr_d[LOG_DEPTH-1:0]];
            end
        end
    end

    assign head_data_o = head_q;
    assign level_o     = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/net_rx_dispatch.sv
// RX dispatch: capture stage with flow filter, FWFT buffer towards the RPC core, full-drop tracking.
// Optional saturating statistics counters are built when NET_RX_DISPATCH_STATS_EN is defined.
module net_rx_dispatch
    import nic_defs::*;
#(
    parameter int LOG_DEPTH    = 5,
    parameter int N_FLOWS      = 16,
    parameter int AFULL_MARGIN = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  NetworkIf             network_rx_in,
    output logic                 rx_out_valid,
    input  logic                 rx_out_ready,
    output NetworkPayload        rx_out_payload,
    output logic [15:0]          rx_out_flow,
    output logic [LOG_DEPTH:0]   fifo_level,
    output logic                 almost_full,
    output logic                 overflow,
    output logic [31:0]          stat_rx_accepted,
    output logic [31:0]          stat_drop_full,
    output logic [31:0]          stat_drop_filter
);

    localparam int DEPTH = 1 << LOG_DEPTH;

    logic          valid_q;
    NetworkPayload data_q;
    logic          flow_ok_q, flow_ok_d;
    logic          overflow_q;
    logic          fifo_full, fifo_empty, pop;
    logic          push_req, accept, drop_full, drop_filter;

    assign flow_ok_d = (32'(network_rx_in.payload[FLOW_ID_LSB +: FLOW_ID_W]) < N_FLOWS);

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= 1'b0;
            data_q    <= '0;
            flow_ok_q <= 1'b0;
        end else begin
            valid_q   <= network_rx_in.valid;
            data_q    <= network_rx_in.payload;
            flow_ok_q <= flow_ok_d;
        end
    end

    assign pop         = rx_out_valid & rx_out_ready;
    assign push_req    = valid_q & flow_ok_q;
    assign drop_filter = valid_q & ~flow_ok_q;
    assign drop_full   = push_req & fifo_full & ~pop;
    assign accept      = push_req & ~drop_full;

    net_rx_sync_fifo #(
        .DATA_WIDTH ($bits(NetworkPayload)),
        .LOG_DEPTH  (LOG_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .srst_i      (reset),
        .push_i      (push_req),
        .push_data_i (data_q),
        .pop_i       (pop),
        .head_data_o (rx_out_payload),
        .level_o     (fifo_level),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign rx_out_valid = ~fifo_empty;
    assign rx_out_flow  = rx_out_payload[FLOW_ID_LSB +: FLOW_ID_W];
    assign almost_full  = (fifo_level >= (LOG_DEPTH+1)'(DEPTH - AFULL_MARGIN));

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if (drop_full) begin
            overflow_q <= 1'b1;
        end
    end
    assign overflow = overflow_q;

`ifdef NET_RX_DISPATCH_STATS_EN
    NetRxStats stats_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stats_q <= '0;
        end else begin
            stats_q.accepted    <= sat_inc(stats_q.accepted, accept);
            stats_q.drop_full   <= sat_inc(stats_q.drop_full, drop_full);
            stats_q.drop_filter <= sat_inc(stats_q.drop_filter, drop_filter);
        end
    end

    assign stat_rx_accepted = stats_q.accepted;
    assign stat_drop_full   = stats_q.drop_full;
    assign stat_drop_filter = stats_q.drop_filter;
`else
    logic unused_stats;
    assign unused_stats     = accept ^ drop_filter;
    assign stat_rx_accepted = 32'd0;
    assign stat_drop_full   = 32'd0;
    assign stat_drop_filter = 32'd0;
`endif

endmodule

// File: tb/tb_net_rx_dispatch.sv
// Randomized bench for net_rx_dispatch against a queue-based model of the accept/drop/order rules.
module tb_net_rx_dispatch;
    import nic_defs::*;

    localparam int LOG_DEPTH    = 5;
    localparam int N_FLOWS      = 16;
    localparam int AFULL_MARGIN = 4;
    localparam int DEPTH        = 1 << LOG_DEPTH;

    logic          clk = 1'b0;
    logic          reset;
    NetworkIf      network_rx_in;
    logic          rx_out_valid;
    logic          rx_out_ready;
    NetworkPayload rx_out_payload;
    logic [15:0]   rx_out_flow;
    logic [LOG_DEPTH:0] fifo_level;
    logic          almost_full;
    logic          overflow;
    logic [31:0]   stat_rx_accepted, stat_drop_full, stat_drop_filter;

    always #5 clk = ~clk;

    net_rx_dispatch #(
        .LOG_DEPTH    (LOG_DEPTH),
        .N_FLOWS      (N_FLOWS),
        .AFULL_MARGIN (AFULL_MARGIN)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .network_rx_in    (network_rx_in),
        .rx_out_valid     (rx_out_valid),
        .rx_out_ready     (rx_out_ready),
        .rx_out_payload   (rx_out_payload),
        .rx_out_flow      (rx_out_flow),
        .fifo_level       (fifo_level),
        .almost_full      (almost_full),
        .overflow         (overflow),
        .stat_rx_accepted (stat_rx_accepted),
        .stat_drop_full   (stat_drop_full),
        .stat_drop_filter (stat_drop_filter)
    );

    // Reference model: pending capture plus an ordered queue of stored payloads.
    NetworkPayload exp_q[$];
    logic          pend_v;
    NetworkPayload pend_p;
    int            m_acc, m_dfull, m_dfilt;
    logic          m_ovf;
    int            n_cmp = 0;
    int            n_bad = 0;

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic NetworkPayload mk(input int flow);
        NetworkPayload p;
        for (int i = 0; i < 16; i++) p[i*32 +: 32] = $urandom;
        p[15:0] = 16'(flow);
        return p;
    endfunction

    task automatic model_edge();
        if (reset) begin
            exp_q.delete();
            pend_v  = 1'b0;
            m_acc   = 0;
            m_dfull = 0;
            m_dfilt = 0;
            m_ovf   = 1'b0;
            return;
        end
        if (exp_q.size() > 0 && rx_out_ready) begin
            $display("pop flow=%0d level=%0d", exp_q[0][15:0], exp_q.size());
            void'(exp_q.pop_front());
        end
        if (pend_v) begin
            if (int'(pend_p[15:0]) >= N_FLOWS) begin
                m_dfilt++;
            end else if (exp_q.size() < DEPTH) begin
                exp_q.push_back(pend_p);
                m_acc++;
            end else begin
                m_dfull++;
                m_ovf = 1'b1;
            end
        end
        pend_v = network_rx_in.valid;
        pend_p = network_rx_in.payload;
    endtask

    task automatic check_all();
        logic exp_valid;
        exp_valid = (exp_q.size() > 0);
        check_eq("valid", 512'(rx_out_valid), 512'(exp_valid));
        check_eq("level", 512'(fifo_level), 512'(exp_q.size()));
        check_eq("almost_full", 512'(almost_full), 512'(exp_q.size() >= DEPTH - AFULL_MARGIN));
        check_eq("overflow", 512'(overflow), 512'(m_ovf));
        if (exp_valid) begin
            check_eq("payload", rx_out_payload, exp_q[0]);
            check_eq("flow", 512'(rx_out_flow), 512'(exp_q[0][15:0]));
        end
`ifdef NET_RX_DISPATCH_STATS_EN
        check_eq("stat_acc", 512'(stat_rx_accepted), 512'(m_acc));
        check_eq("stat_dfull", 512'(stat_drop_full), 512'(m_dfull));
        check_eq("stat_dfilt", 512'(stat_drop_filter), 512'(m_dfilt));
`else
        check_eq("stat_acc", 512'(stat_rx_accepted), 512'(0));
        check_eq("stat_dfull", 512'(stat_drop_full), 512'(0));
        check_eq("stat_dfilt", 512'(stat_drop_filter), 512'(0));
`endif
    endtask

    task automatic cycle(input logic v, input NetworkPayload p, input logic rdy);
        network_rx_in.valid   = v;
        network_rx_in.payload = p;
        rx_out_ready          = rdy;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        reset                 = 1'b1;
        network_rx_in.valid   = 1'b0;
        network_rx_in.payload = '0;
        rx_out_ready          = 1'b0;
        pend_v                = 1'b0;
        pend_p                = '0;
        m_acc = 0; m_dfull = 0; m_dfilt = 0; m_ovf = 1'b0;

        cycle(1'b0, '0, 1'b0);
        check_eq("rst_payload", rx_out_payload, '0);
        cycle(1'b0, '0, 1'b0);
        reset = 1'b0;

        // Single payload, flow 3, consumer ready.
        cycle(1'b1, mk(3), 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1);

        // Burst of 40 into a stalled consumer.
        for (int i = 0; i < 40; i++) cycle(1'b1, mk(int'($urandom_range(0, 15))), 1'b0);
        cycle(1'b0, '0, 1'b0);
        check_eq("burst_level", 512'(fifo_level), 512'(DEPTH));

        // Full FIFO: push and pop land on the same edge.
        cycle(1'b1, mk(7), 1'b0);
        cycle(1'b0, '0, 1'b1);
        check_eq("full_pushpop_level", 512'(fifo_level), 512'(DEPTH));
        for (int i = 0; i < 40; i++) cycle(1'b0, '0, 1'b1);

        // Flow filter boundary.
        cycle(1'b1, mk(16), 1'b1);
        cycle(1'b1, mk(15), 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1);

        // Ready toggling under continuous input.
        for (int i = 0; i < 200; i++) cycle(1'b1, mk(int'($urandom_range(0, 17))), 1'(i % 2));

        // Random traffic with a mostly stalled consumer.
        for (int i = 0; i < 200; i++)
            cycle(1'($urandom_range(0, 3) != 0), mk(int'($urandom_range(0, 17))),
                  1'($urandom_range(0, 2) == 0));
        for (int i = 0; i < 40; i++) cycle(1'b0, '0, 1'b1);

        // Reset with 10 stored entries and one payload in capture; overflow set first.
        for (int i = 0; i < 40; i++) cycle(1'b1, mk(1), 1'b0);
        for (int i = 0; i < 34; i++) cycle(1'b0, '0, 1'b1);
        for (int i = 0; i < 10; i++) cycle(1'b1, mk(int'($urandom_range(0, 15))), 1'b0);
        cycle(1'b1, mk(2), 1'b0);
        reset = 1'b1;
        cycle(1'b1, mk(4), 1'b0);
        reset = 1'b0;
        check_eq("rst_mid_payload", rx_out_payload, '0);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
